run_ctrl: RTL

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 8 +
 rtl/sync_fifo.sv | 39 +++
 rtl/run_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: FSM state encoding and status-bit indices shared by run_ctrl and its users.
package run_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_e;
  localparam int unsigned ST_PASS    = 0;
  localparam int unsigned ST_FAIL    = 1;
  localparam int unsigned ST_TIMEOUT = 2;
  localparam int unsigned ST_W       = 3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic do_push, do_pop;
  // Extra pointer bit tells full from empty when the index bits match.
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  assign rdata   = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: holds a core in reset, times its run, detects tohost termination and logs every store.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       CNT_W        = 32,
  parameter int unsigned       RESET_CYCLES = 4,
  parameter int unsigned       MAX_CYCLES   = 100,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h54,
  parameter logic [DATA_W-1:0] PASS_VAL     = 1,
  parameter int unsigned       LOG_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  output logic              core_reset,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic              log_overflow
);
  localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
  state_e           state_q;
  logic [HW-1:0]    hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic             core_reset_q, done_q, ovf_q;
  logic [ST_W-1:0]  status_q;
  logic             in_run, term, push, pop, full, empty;
  assign in_run = state_q == RUN;
  assign term   = memwrite && (aluout == TOHOST_ADDR);
  assign push   = in_run && memwrite;
  assign pop    = !empty && log_ready;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      status_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (run_en) begin
          state_q <= HOLD;
          hold_q  <= '0;
        end
        HOLD: if (!run_en) state_q <= IDLE;
        else if (hold_q == HW'(RESET_CYCLES - 1)) begin
          state_q      <= RUN;
          core_reset_q <= 1'b0;
          cnt_q        <= '0;
        end else hold_q <= hold_q + HW'(1);
        RUN: if (term) begin
          // A termination store outranks a timeout landing in the same cycle.
          state_q           <= DONE;
          core_reset_q      <= 1'b1;
          done_q            <= 1'b1;
          status_q[ST_PASS] <= writedata == PASS_VAL;
          status_q[ST_FAIL] <= writedata != PASS_VAL;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_q              <= DONE;
          core_reset_q         <= 1'b1;
          done_q               <= 1'b1;
          status_q[ST_TIMEOUT] <= 1'b1;
        end else if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) ovf_q <= 1'b0;
    else ovf_q <= ovf_q | (push && full && !pop);
  end
  sync_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(LOG_DEPTH)
  ) u_log (
    .clk  (clk),
    .rst_n(reset),
    .push (push),
    .pop  (pop),
    .wdata({aluout, writedata}),
    .rdata({log_addr, log_data}),
    .full (full),
    .empty(empty)
  );
  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign pass         = status_q[ST_PASS];
  assign fail         = status_q[ST_FAIL];
  assign timeout      = status_q[ST_TIMEOUT];
  assign cycle_count  = cnt_q;
  assign log_valid    = !empty;
  assign log_overflow = ovf_q;
endmodule
